// File: rtl/avg_pair_sched.sv
// Sequencer for a sample buffer feeding a pairwise-averaging datapath:
// captures cfg_len bytes into the RAM, then streams (j, j+stride) read pairs.
//
// state   | meaning
// IDLE    | waiting for start, config checked here
// LOAD    | accepting input bytes into RAM
// COMPUTE | issuing paired reads, valid/ready to datapath
// DONE    | one-cycle completion pulse, counters cleared
module avg_pair_sched #(
    parameter int DEPTH = 128,
    parameter int AW    = 7,
    parameter int SW    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW:0]   cfg_len,
    input  logic [SW-1:0] cfg_stride,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          mem_we,
    output logic [AW-1:0] mem_waddr,
    output logic          mem_re,
    output logic [AW-1:0] mem_raddr_a,
    output logic [AW-1:0] mem_raddr_b,
    output logic          pair_valid,
    output logic          pair_last,
    input  logic          pair_ready,
    output logic          busy,
    output logic          done,
    output logic          err
);

    typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DONE} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [AW:0]   len_r;
    logic [SW-1:0] str_r;
    logic [AW:0]   wcnt;
    logic [AW:0]   j;
    logic [AW-1:0] last_a;
    logic [AW-1:0] last_b;

    logic [AW:0]   str_ext;
    logic [AW:0]   npairs;
    logic [AW:0]   npairs_m1;
    logic [AW:0]   len_m1;
    logic [AW-1:0] j_b;
    logic          issue;
    logic          accept;
    logic          load_end;
    logic          cfg_bad;

    always_comb begin
        str_ext   = (AW+1)'(str_r);
        npairs    = len_r - str_ext;
        npairs_m1 = npairs - (AW+1)'(1);
        len_m1    = len_r - (AW+1)'(1);
        j_b       = j[AW-1:0] + str_ext[AW-1:0];
        issue     = (state == COMPUTE) && (j < npairs) && (!pair_valid || pair_ready);
        accept    = pair_valid && pair_ready;
        load_end  = (state == LOAD) && in_valid && (wcnt == len_m1);
        cfg_bad   = (32'(cfg_len) < 32'd2) || (32'(cfg_len) > 32'(DEPTH)) ||
                    (cfg_stride == '0) || (32'(cfg_stride) >= 32'(cfg_len));
    end

    always_comb begin
        state_nxt   = state;
        in_ready    = 1'b0;
        mem_we      = 1'b0;
        mem_waddr   = wcnt[AW-1:0];
        mem_re      = issue;
        // Between issues the read addresses stay on the pair being presented.
        mem_raddr_a = issue ? j[AW-1:0] : last_a;
        mem_raddr_b = issue ? j_b : last_b;
        busy        = (state != IDLE);
        done        = (state == DONE);
        unique case (state)
            IDLE: begin
                if (start && !cfg_bad) state_nxt = LOAD;
            end
            LOAD: begin
                in_ready = 1'b1;
                mem_we   = in_valid;
                if (load_end) state_nxt = COMPUTE;
            end
            COMPUTE: begin
                if (accept && pair_last) state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            len_r      <= '0;
            str_r      <= '0;
            wcnt       <= '0;
            j          <= '0;
            last_a     <= '0;
            last_b     <= '0;
            pair_valid <= 1'b0;
            pair_last  <= 1'b0;
            err        <= 1'b0;
        end else begin
            state <= state_nxt;
            err   <= (state == IDLE) && start && cfg_bad;

            if (state == IDLE && start) begin
                len_r <= cfg_len;
                str_r <= cfg_stride;
            end

            if (load_end)
                wcnt <= '0;
            else if (state == LOAD && in_valid)
                wcnt <= wcnt + (AW+1)'(1);

            if (issue) begin
                j          <= j + (AW+1)'(1);
                last_a     <= j[AW-1:0];
                last_b     <= j_b;
                pair_valid <= 1'b1;
                pair_last  <= (j == npairs_m1);
            end else if (pair_ready) begin
                pair_valid <= 1'b0;
                pair_last  <= 1'b0;
            end

            if (state == DONE) begin
                wcnt       <= '0;
                j          <= '0;
                last_a     <= '0;
                last_b     <= '0;
                pair_valid <= 1'b0;
                pair_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_avg_pair_sched.sv
// Scoreboard bench for avg_pair_sched: a behavioural RAM plus a pair queue
// built from the job parameters; a negedge monitor checks every write and accepted pair.
module tb_avg_pair_sched;

    localparam int DEPTH = 128;
    localparam int AW    = 7;
    localparam int SW    = 4;

    logic          clk;
    logic          reset;
    logic          start;
    logic [AW:0]   cfg_len;
    logic [SW-1:0] cfg_stride;
    logic          in_valid;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic          mem_re;
    logic [AW-1:0] mem_raddr_a;
    logic [AW-1:0] mem_raddr_b;
    logic          pair_valid;
    logic          pair_last;
    logic          pair_ready;
    logic          busy;
    logic          done;
    logic          err;

    logic [7:0]    in_data;
    logic [7:0]    ram [DEPTH];
    logic [7:0]    rd_a;
    logic [7:0]    rd_b;

    typedef struct {int a; int b; bit last;} pair_t;
    pair_t         exp_q[$];
    logic [7:0]    model_mem [DEPTH];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wr_seen = 0;
    int exp_len = 0;
    int acc_cnt = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int last_wr_cyc = 0;
    int last_acc_cyc = 0;
    bit first_pending = 0;
    bit done_seen = 0;

    avg_pair_sched #(.DEPTH(DEPTH), .AW(AW), .SW(SW)) dut (
        .clk(clk), .reset(reset), .start(start), .cfg_len(cfg_len),
        .cfg_stride(cfg_stride), .in_valid(in_valid), .in_ready(in_ready),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_re(mem_re),
        .mem_raddr_a(mem_raddr_a), .mem_raddr_b(mem_raddr_b),
        .pair_valid(pair_valid), .pair_last(pair_last), .pair_ready(pair_ready),
        .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // External RAM: registered read data that only moves when mem_re is high.
    always @(posedge clk) begin
        if (mem_we) ram[mem_waddr] <= in_data;
        if (mem_re) begin
            rd_a <= ram[mem_raddr_a];
            rd_b <= ram[mem_raddr_b];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({in_ready, mem_we, mem_re, pair_valid, pair_last, busy, done, err,
                    mem_waddr, mem_raddr_a, mem_raddr_b});
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            if (mem_we) begin
                chk("waddr", 32'(mem_waddr), wr_seen);
                model_mem[wr_seen % DEPTH] = in_data;
                if (wr_seen == exp_len - 1) last_wr_cyc = cyc;
                wr_seen++;
            end
            if (mem_re) chk("re_after_load", wr_seen, exp_len);
            if (pair_valid && first_pending) begin
                chk("first_pv_lat", cyc - last_wr_cyc, 2);
                first_pending = 0;
            end
            if (pair_valid && pair_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_pair: got pair_last=%0d with nothing expected", pair_last);
                end else begin
                    pair_t e;
                    e = exp_q.pop_front();
                    chk("pair_a_data", 32'(rd_a), 32'(model_mem[e.a]));
                    chk("pair_b_data", 32'(rd_b), 32'(model_mem[e.b]));
                    chk("pair_last", 32'(pair_last), 32'(e.last));
                end
                if (pair_last) last_acc_cyc = cyc;
                acc_cnt++;
            end
            if (done) begin
                done_cnt++;
                done_seen = 1;
                chk("done_lat", cyc - last_acc_cyc, 1);
                chk("done_q_empty", exp_q.size(), 0);
            end
            if (err) err_cnt++;
        end
    end

    // vmode: 0 continuous, 1 toggling, 2 random (also pokes start while busy)
    // rmode: 0 ready high, 1 stall 3 cycles on second pair, 2 random ready
    task automatic run_job(input int len, input int str, input int vmode,
                           input int rmode, input int abort_after);
        int n;
        int stall;
        int e0;
        int d0;
        exp_q.delete();
        for (int k = 0; k < len - str; k++)
            exp_q.push_back('{a: k, b: k + str, last: (k == len - str - 1)});
        exp_len = len;
        wr_seen = 0;
        acc_cnt = 0;
        first_pending = 1;
        done_seen = 0;
        e0 = err_cnt;
        in_valid = 1'b0;
        pair_ready = 1'b1;
        cfg_len = 8'(len);
        cfg_stride = 4'(str);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_start", 32'(busy), 1);
        n = 0;
        while (wr_seen < len && n < 2000) begin
            case (vmode)
                0: in_valid = 1'b1;
                1: in_valid = ~in_valid;
                default: in_valid = 1'($urandom_range(0, 1));
            endcase
            in_data = 8'($urandom);
            if (vmode == 2) begin
                start = 1'b1;
                cfg_len = 8'd1;
            end
            tick();
            n++;
        end
        in_valid = 1'b0;
        start = 1'b0;
        chk("load_count", wr_seen, len);
        stall = 0;
        n = 0;
        while (!done_seen && n < 3000) begin
            pair_ready = 1'b1;
            if (rmode == 1 && acc_cnt == 1 && stall < 3) begin
                pair_ready = 1'b0;
                stall++;
                #1;
                chk("bp_valid_held", 32'(pair_valid), 1);
                chk("bp_no_re", 32'(mem_re), 0);
                chk("bp_raddr_a", 32'(mem_raddr_a), 1);
                chk("bp_raddr_b", 32'(mem_raddr_b), 2);
            end else if (rmode == 2) begin
                pair_ready = 1'($urandom_range(0, 1));
            end
            if (abort_after >= 0 && acc_cnt >= abort_after) begin
                d0 = done_cnt;
                reset = 1'b1;
                tick();
                reset = 1'b0;
                pair_ready = 1'b1;
                chk("abort_outs", all_outs(), 0);
                repeat (5) tick();
                chk("abort_no_done", done_cnt, d0);
                chk("abort_idle", 32'(busy), 0);
                exp_q.delete();
                return;
            end
            tick();
            n++;
        end
        pair_ready = 1'b1;
        chk("job_done", 32'(done_seen), 1);
        chk("pair_count", acc_cnt, len - str);
        chk("busy_after_done", 32'(busy), 0);
        chk("no_err_while_busy", err_cnt, e0);
    endtask

    task automatic bad_start(input int len, input int str);
        cfg_len = 8'(len);
        cfg_stride = 4'(str);
        in_valid = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("err_pulse", 32'(err), 1);
        chk("err_busy", 32'(busy), 0);
        chk("err_no_we", 32'(mem_we), 0);
        tick();
        chk("err_one_cycle", 32'(err), 0);
        chk("err_still_idle", 32'(busy), 0);
        in_valid = 1'b0;
    endtask

    initial begin
        int len;
        int str;
        reset = 1'b1;
        start = 1'b0;
        cfg_len = '0;
        cfg_stride = '0;
        in_valid = 1'b0;
        in_data = '0;
        pair_ready = 1'b1;
        repeat (3) tick();
        chk("reset_outs", all_outs(), 0);
        reset = 1'b0;
        tick();
        chk("idle_outs", all_outs(), 0);

        run_job(128, 8, 0, 0, -1);
        run_job(4, 1, 0, 1, -1);
        run_job(16, 3, 1, 0, -1);
        bad_start(1, 1);
        bad_start(8, 0);
        bad_start(8, 8);
        bad_start(129, 1);
        run_job(2, 1, 0, 0, -1);
        run_job(32, 5, 0, 0, 5);
        run_job(20, 7, 0, 0, -1);
        for (int r = 0; r < 6; r++) begin
            len = int'($urandom_range(2, DEPTH));
            str = int'($urandom_range(1, (len - 1 > 15) ? 15 : len - 1));
            run_job(len, str, r % 3, (r % 2 == 0) ? 0 : 2, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/avg_pair_sched.md
Name: avg_pair_sched

Overview:
Controller that sequences a sample-buffer plus pairwise-averaging datapath through two phases. LOAD captures a configurable number of input bytes into an external single-write/dual-read sample RAM. COMPUTE streams address pairs (j, j+STRIDE) to the RAM and presents the paired read as a valid/ready transaction to the averaging datapath. The block owns all RAM addressing, enables and handshakes; it does no arithmetic on sample data.

Parameters:
DEPTH, 128, sample RAM entries (power of 2, >= 4)
AW, 7, RAM address width, log2(DEPTH)
SW, 4, stride field width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
start  in  1  begin a job; sampled only in IDLE
cfg_len  in  AW+1  samples to capture; legal 2..DEPTH
cfg_stride  in  SW  pair distance; legal 1..cfg_len-1
in_valid  in  1  input byte present (data goes straight to RAM)
in_ready  out  1  controller accepts input byte
mem_we  out  1  RAM write enable
mem_waddr  out  AW  RAM write address
mem_re  out  1  RAM read enable; RAM read data registered, updates only when mem_re=1
mem_raddr_a  out  AW  first read address (j)
mem_raddr_b  out  AW  second read address (j+stride)
pair_valid  out  1  RAM read data on both ports is a valid pair for datapath
pair_last  out  1  qualifies final pair of job
pair_ready  in  1  datapath accepts pair
busy  out  1  high in LOAD/COMPUTE/DONE
done  out  1  one-cycle pulse at job end
err  out  1  one-cycle pulse on rejected start

Behaviour:
- Reset: state IDLE; in_ready, mem_we, mem_re, pair_valid, pair_last, busy, done, err = 0; all addresses and counters = 0. Reset at any cycle aborts the job with no done pulse.
- States: IDLE, LOAD, COMPUTE, DONE.
- IDLE: on start, latch cfg_len -> len_r and cfg_stride -> str_r.
  - If legal: go to LOAD next cycle.
  - If cfg_len<2, cfg_len>DEPTH, cfg_stride==0 or cfg_stride>=cfg_len: err=1 next cycle, stay IDLE.
- LOAD:
  - in_ready=1 combinationally.
  - On in_valid: mem_we=in_valid, mem_waddr=wcnt, then wcnt++.
  - When the write with wcnt==len_r-1 occurs, go to COMPUTE next cycle.
  - in_valid gaps stall with no side effect.
- COMPUTE: npairs = len_r - str_r; issue counter j runs 0..npairs-1.
  - issue = (j<npairs) && (!pair_valid || pair_ready).
  - mem_re=issue, with mem_raddr_a=j and mem_raddr_b=j+str_r; j++ on issue.
  - pair_valid is set the cycle after issue. It holds while pair_valid && !pair_ready; RAM output is stable because mem_re=0.
  - pair_last is registered with pair_valid; high when the pair was issued with j==npairs-1.
  - Throughput 1 pair/clk with pair_ready tied high. First pair_valid appears 2 cycles after the final LOAD write (1 cycle state change, 1 cycle RAM read).
  - When the pair with pair_last is accepted (pair_valid && pair_ready): go to DONE.
- DONE: done=1 for exactly one cycle, counters cleared, then IDLE; busy=0 from that IDLE cycle.
- start while busy is ignored (no err); start in the DONE cycle is ignored.
- Addresses never exceed len_r-1, since j+str_r <= len_r-1 by construction. No wrap-around.

Test Plan:
- Reset then job: cfg_len=128, stride=8, in_valid continuous, pair_ready=1.
  - Expect 128 writes at addresses 0..127, then 120 pairs (a,b)=(0,8)..(119,127).
  - pair_last only on (119,127); done 1 cycle after that pair is accepted.
- Backpressure: cfg_len=4, stride=1, pair_ready low for 3 cycles on the 2nd pair.
  - Expect pair_valid held, mem_re=0, RAM addresses frozen at (1,2) until accept.
  - Total 3 pairs, no pair lost or duplicated.
- Input gaps: cfg_len=16, in_valid toggling every cycle.
  - Expect exactly 16 writes with consecutive addresses.
  - COMPUTE starts only after the 16th write.
- Illegal configs: start with (len=1, stride=1), (len=8, stride=0), (len=8, stride=8), (len=129, stride=1).
  - Expect an err pulse each time, busy stays 0, no mem_we.
- Minimum job: len=2, stride=1 -> single pair (0,1) with pair_last=1, then done.
- Reset mid-COMPUTE after 5 pairs.
  - Expect all outputs 0 the next cycle, no done pulse.
  - A fresh job runs correctly from address 0.
